// File: rtl/mu_mul16_if.sv
// Operand/result bundle for the mu_mul16 pipelined multiplier.
// master drives the operands; slave is the multiplier itself.
interface mu_mul16_if #(
  parameter int WIDTH = 16
);
  logic                 in_valid;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   result;
  logic                 out_valid;

  modport master (output in_valid, output a, output b, input result, input out_valid);
  modport slave  (input in_valid, input a, input b, output result, output out_valid);
endinterface

// File: rtl/mu_mul16.sv
// Two-stage unsigned WIDTH x WIDTH multiplier: stage 1 reduces the partial
// products to carry-save form, stage 2 performs the final carry-propagate add.
module mu_mul16 #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  mu_mul16_if.slave  bus
);
  localparam int PW = 2 * WIDTH;

  logic [PW-1:0] sum_d, sum_q;
  logic [PW-1:0] carry_d, carry_q;
  logic          valid_d, valid_q;
  logic [PW-1:0] result_d, result_q;
  logic          out_valid_d, out_valid_q;

  function automatic logic [PW-1:0] csa_sum(input logic [PW-1:0] x,
                                            input logic [PW-1:0] y,
                                            input logic [PW-1:0] z);
    return x ^ y ^ z;
  endfunction

  // Majority bit moves one place up; the bit shifted out of the top is always 0.
  function automatic logic [PW-1:0] csa_carry(input logic [PW-1:0] x,
                                              input logic [PW-1:0] y,
                                              input logic [PW-1:0] z);
    logic [PW-1:0] maj;
    maj = (x & y) | (x & z) | (y & z);
    return {maj[PW-2:0], 1'b0};
  endfunction

  // Stage 1: partial products folded through a linear carry-save chain.
  always_comb begin
    logic [PW-1:0] pp;
    logic [PW-1:0] next_sum;
    pp       = '0;
    next_sum = '0;
    sum_d    = '0;
    carry_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pp       = {{WIDTH{1'b0}}, bus.a & {WIDTH{bus.b[i]}}} << i;
      next_sum = csa_sum(sum_d, carry_d, pp);
      carry_d  = csa_carry(sum_d, carry_d, pp);
      sum_d    = next_sum;
    end
    valid_d = bus.in_valid;
  end

  // Stage 2: carry-propagate add and valid hand-off.
  always_comb begin
    result_d    = sum_q + carry_q;
    out_valid_d = valid_q;
  end

  // Pipeline registers, cleared together by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q       <= '0;
      carry_q     <= '0;
      valid_q     <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      valid_q     <= valid_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_mu_mul16.sv
// Self-checking bench for mu_mul16: directed scenarios plus a randomized
// back-to-back run against a two-cycle-delayed a*b reference.
module tb_mu_mul16;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  mu_mul16_if #(.WIDTH(16)) bus ();

  mu_mul16 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    longint unsigned p;
    p = longint'(x) * longint'(y);
    return p[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y);
    bus.in_valid = v;
    bus.a        = x;
    bus.b        = y;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 16'd5, 16'd7);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.result !== 32'd0 || bus.out_valid !== 1'b0)
        $display("FAIL reset_hold cyc%0d: result=%h out_valid=%b, need 00000000/0", k, bus.result, bus.out_valid);
      else n_pass++;
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL reset_release_lat1: out_valid=%b, need 0", bus.out_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'h0000_0023)
      $display("FAIL reset_release_lat2: result=%h out_valid=%b, need 00000023/1", bus.result, bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_directed();
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic [31:0] te [4];
    ta = '{16'd1, 16'd10, 16'd10, 16'd10101};
    tb = '{16'd0, 16'd1, 16'd10, 16'd10000};
    te = '{32'd0, 32'd10, 32'd100, 32'h0605_4A50};
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k >= 2) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== te[k-2])
          $display("FAIL directed_%0d: result=%h out_valid=%b, need %h/1", k - 2, bus.result, bus.out_valid, te[k-2]);
        else n_pass++;
      end
      if (k < 4) drive(1'b1, ta[k], tb[k]);
      else drive(1'b0, 16'd0, 16'd0);
    end
  endtask

  task automatic test_corners();
    logic [15:0] ta [4];
    logic [15:0] tb [4];
    logic [31:0] te [4];
    ta = '{16'hFFFF, 16'hFFFF, 16'h8000, 16'h0000};
    tb = '{16'hFFFF, 16'h0001, 16'h8000, 16'hFFFF};
    te = '{32'hFFFE_0001, 32'h0000_FFFF, 32'h4000_0000, 32'h0000_0000};
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k >= 2) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== te[k-2])
          $display("FAIL corner_%0d: result=%h out_valid=%b, need %h/1", k - 2, bus.result, bus.out_valid, te[k-2]);
        else n_pass++;
      end
      if (k < 4) drive(1'b1, ta[k], tb[k]);
      else drive(1'b0, 16'd0, 16'd0);
    end
  endtask

  task automatic test_valid_gating();
    logic        tv [4];
    logic [15:0] to [4];
    tv = '{1'b1, 1'b0, 1'b1, 1'b0};
    to = '{16'd3, 16'd0, 16'd4, 16'd0};
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k >= 2) begin
        n_checks++;
        if (bus.out_valid !== tv[k-2])
          $display("FAIL gating_valid_%0d: out_valid=%b, need %b", k - 2, bus.out_valid, tv[k-2]);
        else n_pass++;
        if (tv[k-2]) begin
          n_checks++;
          if (bus.result !== {16'd0, to[k-2]} * {16'd0, to[k-2]})
            $display("FAIL gating_result_%0d: result=%h, need %h", k - 2, bus.result, {16'd0, to[k-2]} * {16'd0, to[k-2]});
          else n_pass++;
        end
      end
      if (k < 4) begin
        if (tv[k]) drive(1'b1, to[k], to[k]);
        else drive(1'b0, 16'($urandom), 16'($urandom));
      end else drive(1'b0, 16'd0, 16'd0);
    end
  endtask

  task automatic test_hold();
    logic [31:0] exp_p;
    exp_p = ref_mul(16'h1234, 16'h00FF);
    drive(1'b1, 16'h1234, 16'h00FF);
    tick();
    tick();
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== exp_p)
        $display("FAIL hold_%0d: result=%h out_valid=%b, need %h/1", k, bus.result, bus.out_valid, exp_p);
      else n_pass++;
    end
    drive(1'b0, 16'd0, 16'd0);
    tick();
    tick();
  endtask

  task automatic test_reset_midflight();
    drive(1'b1, 16'd123, 16'd45);
    tick();
    rst = 1'b1;
    drive(1'b1, 16'd77, 16'd88);
    tick();
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'd0)
      $display("FAIL midflight_reset_edge: result=%h out_valid=%b, need 00000000/0", bus.result, bus.out_valid);
    else n_pass++;
    rst = 1'b0;
    drive(1'b0, 16'd0, 16'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (bus.out_valid !== 1'b0)
        $display("FAIL midflight_after_%0d: out_valid=%b, need 0", k, bus.out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back_random();
    logic [31:0] exp_q [$];
    logic [31:0] exp_p;
    logic [15:0] ra;
    logic [15:0] rb;
    int          n_ops;
    int          n_bad;
    n_ops = 10000;
    n_bad = 0;
    for (int k = 0; k < n_ops + 2; k++) begin
      tick();
      if (k >= 2) begin
        exp_p = exp_q.pop_front();
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.result !== exp_p) begin
          n_bad++;
          if (n_bad <= 10)
            $display("FAIL random_%0d: result=%h out_valid=%b, need %h/1", k - 2, bus.result, bus.out_valid, exp_p);
        end else n_pass++;
      end
      if (k < n_ops) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        if (k % 97 == 0) ra = 16'hFFFF;
        drive(1'b1, ra, rb);
        exp_q.push_back(ref_mul(ra, rb));
      end else drive(1'b0, 16'd0, 16'd0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    drive(1'b0, 16'd0, 16'd0);
    test_reset();
    test_directed();
    test_corners();
    test_valid_gating();
    test_hold();
    test_reset_midflight();
    test_back_to_back_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
